// File: rtl/aig_sweep_pkg.sv
// Shared types and constants for the exhaustive AIG vector sweeper.
package aig_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int MISR_TAP_HI = 17;
   localparam int MISR_TAP_LO = 10;
   localparam int SETTLE_MAX  = 15;

endpackage

// File: rtl/aig_misr.sv
// Multiple-input signature register compacting benchmark responses.
module aig_misr
   import aig_sweep_pkg::*;
#(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             fb;

   assign fb = q_q[MISR_TAP_HI] ^ q_q[MISR_TAP_LO];

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = {q_q[WIDTH-2:0], fb} ^ d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/aig_vector_sweeper.sv
// Exhaustive stimulus sweeper for a combinational benchmark with MISR compaction.
// Optional golden-signature comparator enabled by AIG_SWEEP_GOLDEN_CMP_EN.
//
// state   | meaning
// IDLE    | waiting for start, x_out = 0, signature held
// SETTLE  | pattern driven, waiting SETTLE_CYCLES for the benchmark to settle
// CAPTURE | fold f_in into the MISR, advance or finish
// DONE    | one-cycle completion pulse
module aig_vector_sweeper
   import aig_sweep_pkg::*;
#(
   parameter int N_IN          = 6,
   parameter int N_OUT         = 18,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [N_IN-1:0]  x_out,
   input  logic [N_OUT-1:0] f_in,
   output logic             busy,
   output logic             done,
   output logic [N_OUT-1:0] signature
`ifdef AIG_SWEEP_GOLDEN_CMP_EN
   ,
   input  logic [N_OUT-1:0] golden,
   output logic             mismatch
`endif
);

   localparam int              SW          = $clog2(SETTLE_MAX + 1);
   localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYCLES);
   localparam logic [N_IN-1:0] PAT_LAST    = '1;

   state_t          state_q;
   logic [N_IN-1:0] pat_q;
   logic [SW-1:0]   settle_q;
   logic            busy_q;
   logic            done_q;
   logic            accept;
   logic            misr_en;

   assign accept  = (state_q == IDLE) && start;
   assign misr_en = (state_q == CAPTURE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pat_q    <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  pat_q    <= '0;
                  settle_q <= SETTLE_LOAD;
                  busy_q   <= 1'b1;
                  state_q  <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_q == SW'(1)) begin
                  state_q <= CAPTURE;
               end else begin
                  settle_q <= settle_q - SW'(1);
               end
            end
            CAPTURE: begin
               // last pattern finishes without advancing so the counter never wraps
               if (pat_q == PAT_LAST) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  pat_q    <= pat_q + 1'b1;
                  settle_q <= SETTLE_LOAD;
                  state_q  <= SETTLE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               pat_q   <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   aig_misr #(.WIDTH(N_OUT)) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (misr_en),
      .d   (f_in),
      .q   (signature)
   );

   assign x_out = pat_q;
   assign busy  = busy_q;
   assign done  = done_q;

`ifdef AIG_SWEEP_GOLDEN_CMP_EN
   logic mismatch_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch_q <= 1'b0;
      end else if (accept) begin
         mismatch_q <= 1'b0;
      end else if (state_q == DONE) begin
         mismatch_q <= (signature != golden);
      end
   end

   assign mismatch = mismatch_q;
`endif

endmodule
